// File: rtl/seq_detector_param.sv
// Serial pattern detector (KMP automaton) with Mealy y, registered y_q and a saturating detection count.
// Latency x->y 0 cycles, x->y_q 1 cycle; no backpressure, en qualifies x. SEQ_DET_LOAD_EN adds a runtime pattern load.
module seq_detector_param #(
  parameter int          N       = 4,
  parameter logic [15:0] PATTERN = 16'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8,
  parameter int          SW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
`ifdef SEQ_DET_LOAD_EN
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
`endif
  output logic [SW-1:0]    Q,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] det_cnt
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detector_param: N must be in 2..16");
  end
  if ((PATTERN >> N) != 16'd0) begin : g_bad_pattern
    $error("seq_detector_param: PATTERN wider than N bits");
  end

  function automatic logic pbit(input logic [N-1:0] p, input int i);
    logic [N-1:0] t;
    t = p >> i;
    return t[0];
  endfunction

  // Longest proper border of the pattern: the state to resume from after an overlapping match.
  function automatic logic [SW-1:0] border(input logic [N-1:0] p);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < N; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pbit(p, N-1-j) != pbit(p, k-1-j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return SW'(best);
  endfunction

  // h = first s pattern bits then xb; return longest pattern prefix (< N) that is a suffix of h.
  function automatic logic [SW-1:0] advance(input logic [N-1:0] p, input logic [SW-1:0] s,
                                            input logic xb);
    int   best;
    int   pos;
    logic ok;
    logic hb;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if (k <= int'(s) + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          pos = int'(s) + 1 - k + j;
          hb  = (pos == int'(s)) ? xb : pbit(p, N-1-pos);
          if (hb != pbit(p, N-1-j)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return SW'(best);
  endfunction

  logic [N-1:0]  pat;
  logic          load;
  logic          hit;
  logic [SW-1:0] q_nxt;

`ifdef SEQ_DET_LOAD_EN
  logic [N-1:0] pat_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   pat_r <= PATTERN[N-1:0];
    else if (!clr && pat_load) pat_r <= pat_in;
  end

  assign pat  = pat_r;
  assign load = pat_load & ~clr;
`else
  assign pat  = PATTERN[N-1:0];
  assign load = 1'b0;
`endif

  assign hit = (Q == SW'(N-1)) && (x == pat[0]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Q <= '0;
    else     Q <= q_nxt;
  end

  // Next-state logic
  always_comb begin
    q_nxt = Q;
    if (clr || load) begin
      q_nxt = '0;
    end else if (en) begin
      if (hit) q_nxt = OVERLAP ? border(pat) : '0;
      else     q_nxt = advance(pat, Q, x);
    end
  end

  // Output logic
  always_comb begin
    y = en & ~clr & ~load & ~rst & hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= 1'b0;
    else     y_q <= y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         det_cnt <= '0;
    else if (clr)                    det_cnt <= '0;
    else if (y && (det_cnt != '1))   det_cnt <= det_cnt + 1'b1;
  end

endmodule
